// File: rtl/pcss_axis_link_tx_if.sv
// Bundle of the host AXI-stream and chip-link signals for pcss_axis_link_tx.
// The slave modport is the transmitter; the master modport is host plus chip.
interface pcss_axis_link_tx_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int CHIPDATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]     s_axis_tdata;
  logic                      s_axis_tvalid;
  logic                      s_axis_tlast;
  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep;
  logic                      s_axis_tready;
  logic [CHIPDATA_WIDTH-1:0] link_data_out;
  logic                      link_valid;
  logic                      link_par;
  logic                      link_ready;
  logic                      link_err;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tkeep,
    input  link_ready, link_err,
    output s_axis_tready, link_data_out, link_valid, link_par
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tkeep,
    output link_ready, link_err,
    input  s_axis_tready, link_data_out, link_valid, link_par
  );
endinterface

// File: rtl/pcss_axis_link_tx.sv
// AXI-stream to chip-link transmitter: splits host words into parity-protected
// flits (LSB flit first), replays a flit on chip parity error, goes fatal on retry exhaustion.
module pcss_axis_link_tx #(
  parameter int DATA_WIDTH     = 64,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int PAR_ODD        = 0,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcss_axis_link_tx_if.slave   bus_if,
  output logic [CNT_W-1:0]     sent_word_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic                 fatal_err
);
  localparam int NFLIT = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int BPF   = CHIPDATA_WIDTH / 8;
  localparam int KW    = DATA_WIDTH / 8;
  localparam int IDX_W = (NFLIT > 1) ? $clog2(NFLIT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CHECK = 2'd2,
    FATAL = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic                      tlast_q, tlast_d;
  logic [IDX_W-1:0]          last_idx_q, last_idx_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [RTY_W-1:0]          retry_q, retry_d;
  logic [CNT_W-1:0]          sent_q, sent_d;
  logic [CNT_W-1:0]          errc_q, errc_d;
  logic [CNT_W-1:0]          pkt_q, pkt_d;
  logic                      tready_q, tready_d;
  logic                      valid_q, valid_d;
  logic [CHIPDATA_WIDTH-1:0] data_q, data_d;
  logic                      par_q, par_d;
  logic                      fatal_q, fatal_d;
  logic [IDX_W:0]            nflit_s;

  // Flit count is set by the highest flit that has any byte enabled.
  function automatic logic [IDX_W:0] calc_nflit(input logic [KW-1:0] keep);
    logic [IDX_W:0] n;
    n = '0;
    for (int f = 0; f < NFLIT; f++) begin
      if (|keep[f*BPF +: BPF]) begin
        n = (IDX_W+1)'(f + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  function automatic logic flit_par(input logic [CHIPDATA_WIDTH-1:0] flit);
    return (^flit) ^ 1'(PAR_ODD);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign nflit_s = calc_nflit(bus_if.s_axis_tkeep);

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    tlast_d    = tlast_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    sent_d     = sent_q;
    errc_d     = errc_q;
    pkt_d      = pkt_q;
    case (state_q)
      IDLE: begin
        if (bus_if.s_axis_tvalid && tready_q) begin
          word_d  = bus_if.s_axis_tdata;
          tlast_d = bus_if.s_axis_tlast;
          if (nflit_s != '0) begin
            last_idx_d = IDX_W'(nflit_s - (IDX_W+1)'(1));
            idx_d      = '0;
            retry_d    = '0;
            state_d    = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus_if.link_ready) begin
          state_d = CHECK;
        end else begin
          state_d = SEND;
        end
      end
      CHECK: begin
        if (bus_if.link_err) begin
          errc_d = sat_inc(errc_q);
          if (retry_q == RTY_W'(MAX_RETRY)) begin
            state_d = FATAL;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = SEND;
          end
        end else if (idx_q != last_idx_q) begin
          idx_d   = idx_q + IDX_W'(1);
          retry_d = '0;
          state_d = SEND;
        end else begin
          sent_d  = sat_inc(sent_q);
          if (tlast_q) begin
            pkt_d = sat_inc(pkt_q);
          end else begin
            pkt_d = pkt_q;
          end
          state_d = IDLE;
        end
      end
      FATAL: begin
        state_d = FATAL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tready_d = (state_d == IDLE);
    valid_d  = (state_d == SEND);
    fatal_d  = (state_d == FATAL);
    if (valid_d) begin
      data_d = word_d[idx_d*CHIPDATA_WIDTH +: CHIPDATA_WIDTH];
      par_d  = flit_par(word_d[idx_d*CHIPDATA_WIDTH +: CHIPDATA_WIDTH]);
    end else begin
      data_d = '0;
      par_d  = 1'b0;
    end
  end

  // State, word buffer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      tlast_q    <= 1'b0;
      last_idx_q <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      sent_q     <= '0;
      errc_q     <= '0;
      pkt_q      <= '0;
      tready_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      par_q      <= 1'b0;
      fatal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      tlast_q    <= tlast_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      sent_q     <= sent_d;
      errc_q     <= errc_d;
      pkt_q      <= pkt_d;
      tready_q   <= tready_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      par_q      <= par_d;
      fatal_q    <= fatal_d;
    end
  end

  assign bus_if.s_axis_tready = tready_q;
  assign bus_if.link_valid    = valid_q;
  assign bus_if.link_data_out = data_q;
  assign bus_if.link_par      = par_q;
  assign sent_word_cnt        = sent_q;
  assign err_cnt              = errc_q;
  assign pkt_cnt              = pkt_q;
  assign fatal_err            = fatal_q;
endmodule

// File: tb/tb_pcss_axis_link_tx.sv
// Randomised and directed bench for pcss_axis_link_tx: an even-parity 16-bit-counter
// instance and an odd-parity 2-bit-counter instance share stimulus and one flit/counter model.
module tb_pcss_axis_link_tx;
  localparam int DW   = 64;
  localparam int CW   = 16;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pcss_axis_link_tx_if #(.DATA_WIDTH(DW), .CHIPDATA_WIDTH(CW)) ev_if ();
  pcss_axis_link_tx_if #(.DATA_WIDTH(DW), .CHIPDATA_WIDTH(CW)) od_if ();

  assign od_if.s_axis_tdata  = ev_if.s_axis_tdata;
  assign od_if.s_axis_tvalid = ev_if.s_axis_tvalid;
  assign od_if.s_axis_tlast  = ev_if.s_axis_tlast;
  assign od_if.s_axis_tkeep  = ev_if.s_axis_tkeep;
  assign od_if.link_ready    = ev_if.link_ready;
  assign od_if.link_err      = ev_if.link_err;

  logic [15:0] ev_sent, ev_err, ev_pkt;
  logic        ev_fatal;
  logic [1:0]  od_sent, od_err, od_pkt;
  logic        od_fatal;

  pcss_axis_link_tx #(.DATA_WIDTH(DW), .CHIPDATA_WIDTH(CW), .PAR_ODD(0), .MAX_RETRY(MAXR), .CNT_W(16)) u_ev (
    .clk(clk), .rst_n(rst_n), .bus_if(ev_if.slave),
    .sent_word_cnt(ev_sent), .err_cnt(ev_err), .pkt_cnt(ev_pkt), .fatal_err(ev_fatal));

  pcss_axis_link_tx #(.DATA_WIDTH(DW), .CHIPDATA_WIDTH(CW), .PAR_ODD(1), .MAX_RETRY(MAXR), .CNT_W(2)) u_od (
    .clk(clk), .rst_n(rst_n), .bus_if(od_if.slave),
    .sent_word_cnt(od_sent), .err_cnt(od_err), .pkt_cnt(od_pkt), .fatal_err(od_fatal));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending flits of the current word plus transaction-level counters.
  logic [CW-1:0] mq[$];
  int  m_nflit, m_retry, m_sent, m_err, m_pkt;
  logic m_last;
  bit  m_pend, m_fatal;
  int  cyc_no = 0;
  int  acc_cyc, valid_cycles;
  logic [CW-1:0] lg_data[$];
  int  lg_cyc[$];
  logic lg_par[$], lg_opar[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic bit m_idle();
    return (mq.size() == 0) && !m_pend && !m_fatal;
  endfunction

  function automatic bit m_valid();
    return (mq.size() != 0) && !m_pend && !m_fatal;
  endfunction

  function automatic int nflit_of(input logic [7:0] tk);
    int n = 0;
    for (int f = 0; f < 4; f++) if (tk[f*2 +: 2] != 2'b00) n = f + 1;
    return n;
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic check_outputs();
    chk("tready", 64'(ev_if.s_axis_tready), 64'(m_idle()));
    chk("valid", 64'(ev_if.link_valid), 64'(m_valid()));
    chk("fatal", 64'(ev_fatal), 64'(m_fatal));
    chk("sent_cnt", 64'(ev_sent), 64'(m_sent));
    chk("err_cnt", 64'(ev_err), 64'(m_err));
    chk("pkt_cnt", 64'(ev_pkt), 64'(m_pkt));
    chk("od_tready", 64'(od_if.s_axis_tready), 64'(m_idle()));
    chk("od_valid", 64'(od_if.link_valid), 64'(m_valid()));
    chk("od_fatal", 64'(od_fatal), 64'(m_fatal));
    chk("od_sent_sat", 64'(od_sent), 64'(sat3(m_sent)));
    chk("od_err_sat", 64'(od_err), 64'(sat3(m_err)));
    chk("od_pkt_sat", 64'(od_pkt), 64'(sat3(m_pkt)));
    if (m_valid()) begin
      chk("flit_data", 64'(ev_if.link_data_out), 64'(mq[0]));
      chk("flit_par", 64'(ev_if.link_par), 64'(^mq[0]));
      chk("od_flit_data", 64'(od_if.link_data_out), 64'(mq[0]));
      chk("od_flit_par", 64'(od_if.link_par), 64'(~^mq[0]));
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model past the edge.
  task automatic cyc(input logic tv, input logic [63:0] td, input logic [7:0] tk,
                     input logic tl, input logic lr, input logic le);
    bit acc_w, acc_f, do_chk;
    int n;
    ev_if.s_axis_tvalid = tv;
    ev_if.s_axis_tdata  = td;
    ev_if.s_axis_tkeep  = tk;
    ev_if.s_axis_tlast  = tl;
    ev_if.link_ready    = lr;
    ev_if.link_err      = le;
    check_outputs();
    acc_w  = tv && m_idle();
    acc_f  = m_valid() && lr;
    do_chk = m_pend;
    if (ev_if.link_valid) valid_cycles++;
    if (acc_f) begin
      lg_data.push_back(ev_if.link_data_out);
      lg_par.push_back(ev_if.link_par);
      lg_opar.push_back(od_if.link_par);
      lg_cyc.push_back(cyc_no);
    end
    if (acc_w) acc_cyc = cyc_no;
    @(posedge clk);
    #1;
    cyc_no++;
    if (do_chk) begin
      if (le) begin
        m_err++;
        if (m_retry == MAXR) begin
          m_fatal = 1'b1;
          mq.delete();
        end else begin
          m_retry++;
        end
      end else begin
        void'(mq.pop_front());
        m_retry = 0;
        if (mq.size() == 0) begin
          m_sent++;
          if (m_last) m_pkt++;
        end
      end
    end
    m_pend = acc_f;
    if (acc_w) begin
      n = nflit_of(tk);
      m_nflit = n;
      m_last  = tl;
      m_retry = 0;
      for (int i = 0; i < n; i++) mq.push_back(td[i*CW +: CW]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ev_if.s_axis_tvalid = 1'b0;
    ev_if.s_axis_tdata  = '0;
    ev_if.s_axis_tkeep  = '0;
    ev_if.s_axis_tlast  = 1'b0;
    ev_if.link_ready    = 1'b0;
    ev_if.link_err      = 1'b0;
    #1;
    chk("rst_tready", 64'(ev_if.s_axis_tready), 64'(0));
    chk("rst_valid", 64'(ev_if.link_valid), 64'(0));
    chk("rst_par", 64'(ev_if.link_par), 64'(0));
    chk("rst_data", 64'(ev_if.link_data_out), 64'(0));
    chk("rst_fatal", 64'(ev_fatal), 64'(0));
    chk("rst_cnts", 64'({ev_sent, ev_err, ev_pkt}), 64'(0));
    chk("rst_od", 64'({od_if.s_axis_tready, od_if.link_valid, od_if.link_par, od_fatal, od_sent}), 64'(0));
    mq.delete();
    m_pend = 1'b0; m_fatal = 1'b0; m_retry = 0;
    m_sent = 0; m_err = 0; m_pkt = 0; m_nflit = 0; m_last = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // Send one word with an optional stall on one flit and errors on the checks of one flit.
  task automatic run_word(input logic [63:0] td, input logic [7:0] tk, input logic tl,
                          input int stall_flit, input int stall_n, input int err_flit, input int err_n);
    int stalls = 0, errs = 0, guard = 0, cur;
    bit first = 1'b1;
    logic lr, le;
    lg_data.delete(); lg_par.delete(); lg_opar.delete(); lg_cyc.delete();
    valid_cycles = 0;
    while ((first || !m_idle()) && !m_fatal && guard < 200) begin
      cur = m_nflit - mq.size();
      lr = 1'b1;
      if (!first && m_valid() && cur == stall_flit && stalls < stall_n) begin
        lr = 1'b0;
        stalls++;
      end
      le = 1'b0;
      if (m_pend && cur == err_flit && errs < err_n) begin
        le = 1'b1;
        errs++;
      end
      cyc(first, td, tk, tl, lr, le);
      first = 1'b0;
      guard++;
    end
    if (guard >= 200) chk("word_timeout", 64'(guard), 64'(0));
  endtask

  localparam logic [63:0] W0 = 64'h0004_0003_0002_0001;

  initial begin
    logic [CW-1:0] exp_d[5];
    logic [7:0] tk;
    int n;
    #2;
    do_reset();

    // Basic word, zero-wait link.
    run_word(W0, 8'hFF, 1'b0, -1, 0, -1, 0);
    chk("t1_nflits", 64'(lg_data.size()), 64'(4));
    exp_d = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000};
    for (int i = 0; i < 4 && i < lg_data.size(); i++) begin
      chk("t1_data", 64'(lg_data[i]), 64'(exp_d[i]));
      chk("t1_cycle", 64'(lg_cyc[i] - acc_cyc), 64'(2*i + 1));
    end
    if (lg_par.size() == 4) begin
      chk("t1_par", 64'({lg_par[0], lg_par[1], lg_par[2], lg_par[3]}), 64'(4'b1101));
      chk("t1_odd_par", 64'({lg_opar[0], lg_opar[1], lg_opar[2], lg_opar[3]}), 64'(4'b0010));
    end
    chk("t1_sent", 64'(ev_sent), 64'(1));
    chk("t1_valid_cycles", 64'(valid_cycles), 64'(4));

    // Link stalls 5 cycles on flit 1.
    do_reset();
    run_word(W0, 8'hFF, 1'b0, 1, 5, -1, 0);
    chk("t2_nflits", 64'(lg_data.size()), 64'(4));
    for (int i = 0; i < 4 && i < lg_data.size(); i++) chk("t2_order", 64'(lg_data[i]), 64'(exp_d[i]));
    chk("t2_valid_cycles", 64'(valid_cycles), 64'(9));

    // One parity error after flit 2.
    do_reset();
    run_word(W0, 8'hFF, 1'b0, -1, 0, 2, 1);
    exp_d = '{16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h0004};
    chk("t3_nflits", 64'(lg_data.size()), 64'(5));
    for (int i = 0; i < 5 && i < lg_data.size(); i++) chk("t3_order", 64'(lg_data[i]), 64'(exp_d[i]));
    chk("t3_err", 64'(ev_err), 64'(1));
    chk("t3_sent", 64'(ev_sent), 64'(1));

    // Retry exhaustion on flit 0.
    do_reset();
    run_word(W0, 8'hFF, 1'b0, -1, 0, 0, 4);
    chk("t4_fatal", 64'(ev_fatal), 64'(1));
    chk("t4_err", 64'(ev_err), 64'(4));
    for (int i = 0; i < 5; i++) cyc(1'b1, W0, 8'hFF, 1'b0, 1'b1, 1'b1);
    chk("t4_tready_held", 64'(ev_if.s_axis_tready), 64'(0));
    chk("t4_fatal_held", 64'(ev_fatal), 64'(1));

    // Trimmed word with tlast, then an all-zero tkeep word.
    do_reset();
    run_word(64'hDEAD_BEEF_1357_2468, 8'h0F, 1'b1, -1, 0, -1, 0);
    chk("t5_nflits", 64'(lg_data.size()), 64'(2));
    chk("t5_pkt", 64'(ev_pkt), 64'(1));
    run_word(64'h1111_2222_3333_4444, 8'h00, 1'b1, -1, 0, -1, 0);
    chk("t5_drop_valid", 64'(valid_cycles), 64'(0));
    chk("t5_drop_cnts", 64'({ev_sent, ev_pkt}), 64'({16'd1, 16'd1}));

    // Reset while flit 2 is on the link; next word starts at flit 0.
    do_reset();
    cyc(1'b1, W0, 8'hFF, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(m_valid() && mq.size() == 2) && n < 20) begin
      cyc(1'b0, W0, 8'hFF, 1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("t6_on_flit2", 64'(ev_if.link_data_out), 64'(16'h0003));
    do_reset();
    run_word(64'h0008_0007_0006_0005, 8'hFF, 1'b0, -1, 0, -1, 0);
    chk("t6_restart_flit0", 64'(lg_data.size() > 0 ? lg_data[0] : 16'hFFFF), 64'(16'h0005));

    // Randomised traffic: ready stalls, sparse errors, noise on link_err, occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        n  = $urandom_range(0, 8);
        tk = 8'((16'h1 << n) - 16'h1);
      end else begin
        tk = 8'($urandom);
      end
      cyc(1'($urandom_range(0, 9) < 6), {$urandom, $urandom}, tk, 1'($urandom),
          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 2));
      if (m_fatal && $urandom_range(0, 7) == 0) do_reset();
      else if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pcss_axis_link_tx.md
Name: pcss_axis_link_tx

Overview:
- Parametrised AXI-stream-to-chip-link transmitter for the PCSS host interface.
- Accepts DATA_WIDTH-bit AXI-stream words from the host and serialises each word into CHIPDATA_WIDTH-bit flits, least-significant flit first.
- Generates per-flit parity, drives the chip's recv_data_* port, and retransmits a flit when the chip flags a parity error.
- Successor to the fixed 64-to-16 send path: adds tkeep-based flit trimming, selectable parity sense, bounded retry with sticky fatal error, and status counters.

Parameters:
- DATA_WIDTH, 64, AXI-stream data width; must be an integer multiple of CHIPDATA_WIDTH, ratio 1..8.
- CHIPDATA_WIDTH, 16, chip link flit width; multiple of 8.
- PAR_ODD, 0, 0 = even parity (par = ^data), 1 = odd parity (par = ~^data).
- MAX_RETRY, 3, retransmissions allowed per flit before fatal error.
- CNT_W, 16, width of the status counters.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- s_axis_tdata, in, DATA_WIDTH, host word.
- s_axis_tvalid, in, 1, host word valid.
- s_axis_tlast, in, 1, end-of-packet marker; passed to status only, does not affect flit framing.
- s_axis_tkeep, in, DATA_WIDTH/8, byte enables; low-contiguous.
- s_axis_tready, out, 1, block can accept a word.
- link_data_out, out, CHIPDATA_WIDTH, flit to the chip (drives recv_data_in_*).
- link_valid, out, 1, flit valid.
- link_par, out, 1, flit parity.
- link_ready, in, 1, chip accepts the flit this cycle.
- link_err, in, 1, chip parity error for the flit accepted in the previous cycle.
- sent_word_cnt, out, CNT_W, words fully delivered; saturating.
- err_cnt, out, CNT_W, link_err events counted; saturating.
- pkt_cnt, out, CNT_W, delivered words that carried tlast; saturating.
- fatal_err, out, 1, sticky retry exhaustion.

Behaviour:
- Reset (async, rst_n = 0):
  - State returns to IDLE; all counters are 0.
  - link_valid, link_par and fatal_err are 0; link_data_out is 0.
  - s_axis_tready is 0 while rst_n = 0 and becomes 1 in the first cycle after release.
  - Reset asserted mid-word discards the word; no partial flits are replayed afterwards.
- States: IDLE, SEND, CHECK, FATAL.
- IDLE:
  - s_axis_tready = 1 and link_valid = 0.
  - On tvalid && tready, register the word, tkeep and tlast.
  - Compute nflit = highest flit index with any tkeep bit set, plus 1.
  - If nflit = 0 (tkeep all zero), drop the word: no flits are sent and no counter increments; stay in IDLE.
  - Otherwise set idx = 0 and retry = 0, then go to SEND.
- SEND:
  - link_valid = 1, link_data_out = word[idx*CHIPDATA_WIDTH +: CHIPDATA_WIDTH], link_par computed combinationally from that flit.
  - Data and valid stay stable while link_ready = 0.
  - On link_ready = 1, go to CHECK.
- CHECK (exactly one cycle; link_valid = 0; link_err is sampled here):
  - link_err = 1: increment err_cnt. If retry == MAX_RETRY, go to FATAL. Otherwise retry++ and return to SEND with the same idx.
  - link_err = 0 and idx < nflit-1: idx++, retry = 0, go to SEND.
  - link_err = 0 and idx == nflit-1: sent_word_cnt++, pkt_cnt++ if the stored tlast = 1, go to IDLE.
- FATAL: fatal_err = 1, s_axis_tready = 0, link_valid = 0. Only reset leaves this state.
- link_err outside CHECK is ignored.
- Latency and throughput:
  - A word accepted at the clock edge ending cycle t drives flit 0 with link_valid in cycle t+1.
  - With a zero-wait link, each flit takes 2 cycles; a full word takes 2*nflit cycles; tready returns 1 in the cycle after the final CHECK.
- Counters saturate at 2^CNT_W-1 without wrapping.
- tkeep must be low-contiguous; behaviour with non-contiguous tkeep is defined only by the nflit rule above.

Test Plan:
- 64/16, PAR_ODD=0, tkeep=0xFF, word 0x0004_0003_0002_0001, link_ready=1, no err:
  - Flits 0x0001, 0x0002, 0x0003, 0x0004 on cycles t+1, t+3, t+5, t+7.
  - link_par = 1, 1, 0, 1 (flit 0x0003 has even popcount, so even parity gives 0).
  - sent_word_cnt = 1.
- Same word with link_ready held 0 for 5 cycles on flit 1: flit 1 data, valid and par stay stable for all 5 cycles; no duplicate flit; final order unchanged.
- link_err = 1 in CHECK after flit 2: flit 0x0003 is resent, err_cnt = 1, sent_word_cnt = 1 at the end.
- link_err asserted on 4 consecutive CHECKs of flit 0 with MAX_RETRY=3: fatal_err = 1 after the 4th, err_cnt = 4, tready stays 0 until reset.
- tkeep = 0x0F with tlast = 1: only 2 flits are sent, pkt_cnt = 1. tkeep = 0x00: no link_valid, counters unchanged.
- rst_n pulsed low during flit 2: all outputs go to 0 immediately; the next word starts at flit 0. Repeat the first scenario with PAR_ODD=1: parity is inverted to 0, 0, 1, 0.
